// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry fetch-to-decode instruction buffer.
// Holds {instr, pc, pc_plus4} in a circular FIFO and hands the head entry to
// decode over a valid/ready handshake. in_ready comes from registered
// occupancy only, so it can drive the PC enable without a combinational loop
// through decode or the branch unit. A taken branch (flush) empties the
// buffer and drops the same-cycle fetch.
module if_id_buffer #(
  parameter int WORD      = 32,
  parameter int INSTR_LEN = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [WORD-1:0]      in_pc,
  input  logic [WORD-1:0]      in_pc_plus4,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [INSTR_LEN-1:0] out_instr,
  output logic [WORD-1:0]      out_pc,
  output logic [WORD-1:0]      out_pc_plus4,
  input  logic                 out_ready,
  output logic [1:0]           count,
  output logic [CNT_W-1:0]     stall_cycles
);

  // Entry payloads; never reset because every output is masked by out_valid.
  logic [INSTR_LEN-1:0] instr_mem [2];
  logic [WORD-1:0]      pc_mem    [2];
  logic [WORD-1:0]      pc4_mem   [2];

  logic       head;
  logic       tail;
  logic [1:0] occ;
  logic       push;
  logic       pop;
  logic       stall;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign count     = occ;

  // Flush wins over both handshakes: nothing is captured and nothing popped.
  assign push  = in_valid & in_ready & ~flush;
  assign pop   = out_valid & out_ready & ~flush;
  assign stall = in_valid & ~in_ready & ~flush;

  assign out_instr    = out_valid ? instr_mem[head] : '0;
  assign out_pc       = out_valid ? pc_mem[head]    : '0;
  assign out_pc_plus4 = out_valid ? pc4_mem[head]   : '0;

  // Pointer, occupancy and stall-statistic state; flush rewinds both pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ          <= 2'd0;
      head         <= 1'b0;
      tail         <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall) stall_cycles <= sat_inc(stall_cycles);
      if (flush) begin
        occ  <= 2'd0;
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (push) tail <= ~tail;
        if (pop)  head <= ~head;
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // Capture the fetched instruction into the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= in_instr;
      pc_mem[tail]    <= in_pc;
      pc4_mem[tail]   <= in_pc_plus4;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: hand-computed vector table, directed stream,
// asynchronous-reset and saturation sequences, then randomized traffic
// compared against a queue-based model of the buffer.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pc_plus4 = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic [1:0]  count;
  logic [15:0] stall_cycles;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_instr, s_out_pc, s_out_pc_plus4;
  logic [1:0]  s_count;
  logic [3:0]  s_stall;

  if_id_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_ready(out_ready),
    .count(count), .stall_cycles(stall_cycles)
  );

  if_id_buffer #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_ready(s_in_ready),
    .flush(flush), .out_valid(s_out_valid), .out_instr(s_out_instr),
    .out_pc(s_out_pc), .out_pc_plus4(s_out_pc_plus4), .out_ready(out_ready),
    .count(s_count), .stall_cycles(s_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    logic [1:0]  c;
    logic        ov;
    logic [31:0] opc;
    logic        ir;
    logic [15:0] st;
  } vec_t;

  ent_t mq[$];
  int   m_stall16 = 0;
  int   m_stall4  = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".count"},     64'(count),        64'(mq.size()));
    chk({tag, ".out_valid"}, 64'(out_valid),    64'(mq.size() != 0));
    chk({tag, ".out_instr"}, 64'(out_instr),    64'(h.instr));
    chk({tag, ".out_pc"},    64'(out_pc),       64'(h.pc));
    chk({tag, ".out_pc4"},   64'(out_pc_plus4), 64'(h.pc4));
    chk({tag, ".stall"},     64'(stall_cycles), 64'(m_stall16));
    chk({tag, ".s_count"},   64'(s_count),      64'(mq.size()));
    chk({tag, ".s_out_pc"},  64'(s_out_pc),     64'(h.pc));
    chk({tag, ".s_stall"},   64'(s_stall),      64'(m_stall4));
  endtask

  // Called just after a rising edge: apply inputs, check in_ready, clock once,
  // advance the model and compare every output.
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl, input string tag);
    logic push, pop, stl;
    ent_t e;
    in_valid    = iv;
    in_pc       = pc;
    in_pc_plus4 = pc + 32'd4;
    in_instr    = instr;
    out_ready   = ordy;
    flush       = fl;
    #1;
    chk({tag, ".in_ready"},   64'(in_ready),   64'(mq.size() != 2));
    chk({tag, ".s_in_ready"}, 64'(s_in_ready), 64'(mq.size() != 2));
    push = iv && (mq.size() < 2) && !fl;
    pop  = (mq.size() > 0) && ordy && !fl;
    stl  = iv && (mq.size() == 2) && !fl;
    e    = {instr, pc, pc + 32'd4};
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    if (stl) begin
      if (m_stall16 < 65535) m_stall16++;
      if (m_stall4 < 15) m_stall4++;
    end
    #1;
    check_model(tag);
  endtask

  vec_t vt[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-pressure then flush-while-full, expectations worked out by hand.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 2'd1, 1'b1, 32'h00, 1'b1, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h04, 2'd2, 1'b1, 32'h00, 1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h08, 2'd2, 1'b1, 32'h00, 1'b0, 16'd1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h08, 2'd2, 1'b1, 32'h00, 1'b0, 16'd2};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h08, 2'd1, 1'b1, 32'h04, 1'b1, 16'd3};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h08, 2'd1, 1'b1, 32'h08, 1'b1, 16'd3};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h0C, 2'd0, 1'b0, 32'h00, 1'b1, 16'd3};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h10, 2'd1, 1'b1, 32'h10, 1'b1, 16'd3};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h14, 2'd2, 1'b1, 32'h10, 1'b0, 16'd3};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h40, 2'd0, 1'b0, 32'h00, 1'b1, 16'd3};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h40, 2'd1, 1'b1, 32'h40, 1'b1, 16'd3};
    vt[11] = '{1'b0, 1'b1, 1'b0, 32'h44, 2'd0, 1'b0, 32'h00, 1'b1, 16'd3};

    // Reset state while reset is held low.
    #2;
    check_model("rst");
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    check_model("rst_rel");

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].iv, vt[i].pc, 32'h00500093 + vt[i].pc, vt[i].ordy, vt[i].fl, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_count", i), 64'(count),     64'(vt[i].c));
      chk($sformatf("vec%0d.t_valid", i), 64'(out_valid), 64'(vt[i].ov));
      chk($sformatf("vec%0d.t_pc", i),    64'(out_pc),    64'(vt[i].opc));
      chk($sformatf("vec%0d.t_ready", i), 64'(in_ready),  64'(vt[i].ir));
      chk($sformatf("vec%0d.t_stall", i), 64'(stall_cycles), 64'(vt[i].st));
      if (!vt[i].ov) chk($sformatf("vec%0d.t_instr0", i), 64'(out_instr), 64'd0);
    end

    // Simultaneous push/pop at count 1: one instruction per cycle, pointers wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i), 32'h00500093 + 32'(i), 1'b1, 1'b0, $sformatf("strm%0d", i));
      chk($sformatf("strm%0d.t_count", i), 64'(count),        64'd1);
      chk($sformatf("strm%0d.t_pc", i),    64'(out_pc),       64'(4 * i));
      chk($sformatf("strm%0d.t_pc4", i),   64'(out_pc_plus4), 64'(4 * i + 4));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "strm_drain");

    // Asynchronous reset between clock edges with the buffer full.
    drive(1'b1, 32'h100, 32'hAAAA0001, 1'b0, 1'b0, "ar_fill0");
    drive(1'b1, 32'h104, 32'hAAAA0002, 1'b0, 1'b0, "ar_fill1");
    drive(1'b1, 32'h108, 32'hAAAA0003, 1'b0, 1'b0, "ar_stall");
    #2 reset = 1'b0;
    #1;
    mq.delete();
    m_stall16 = 0;
    m_stall4  = 0;
    chk("ar.out_valid", 64'(out_valid), 64'd0);
    chk("ar.count",     64'(count),     64'd0);
    chk("ar.in_ready",  64'(in_ready),  64'd1);
    chk("ar.stall",     64'(stall_cycles), 64'd0);
    chk("ar.out_pc",    64'(out_pc),    64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ar_idle");

    // Stall 20 cycles: the 4-bit counter sticks at 15, the 16-bit one reaches 20.
    drive(1'b1, 32'h200, 32'h11111111, 1'b0, 1'b0, "sat_fill0");
    drive(1'b1, 32'h204, 32'h22222222, 1'b0, 1'b0, "sat_fill1");
    for (int i = 0; i < 20; i++)
      drive(1'b1, 32'h208, 32'h33333333, 1'b0, 1'b0, $sformatf("sat%0d", i));
    chk("sat.s_stall_15", 64'(s_stall),      64'd15);
    chk("sat.stall_20",   64'(stall_cycles), 64'd20);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $sformatf("rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
